gray_step_decoder: RTL and testbench

- Receive side of the 3-bit Gray-code counter interface. Samples a Gray-coded input and converts it to binary.
- Classifies each new sample as a forward step, backward step, hold, or illegal jump, and keeps a wrapping signed position count.
- Counts illegal transitions and latches a fault state when too many occur. Sits downstream of any Gray-code counter or encoder in the design.

---
 rtl/gray_step_decoder_if.sv | 29 ++
 rtl/gray_step_decoder.sv | 163 ++++++++++++++++
 tb/tb_gray_step_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_step_decoder_if.sv
// Bus between a Gray-code source and gray_step_decoder: sample strobe and clear in,
// decoded value, position, step/error pulses and lock status out.
interface gray_step_decoder_if #(
  parameter int WIDTH = 3,
  parameter int POS_W = 8
);
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic [POS_W-1:0] pos_out;
  logic             step_up;
  logic             step_dn;
  logic             dir;
  logic             err;
  logic [3:0]       err_cnt;
  logic             locked;
  logic             fault;

  modport master (
    output clr, in_valid, gray_in,
    input  bin_out, pos_out, step_up, step_dn, dir, err, err_cnt, locked, fault
  );

  modport slave (
    input  clr, in_valid, gray_in,
    output bin_out, pos_out, step_up, step_dn, dir, err, err_cnt, locked, fault
  );
endinterface

// File: rtl/gray_step_decoder.sv
// Gray-code step decoder: converts samples to binary, classifies steps, tracks position.
// Optional GRAY_DECODER_SYNC_EN adds a two-flop input synchronizer for asynchronous sources.
module gray_step_decoder #(
  parameter int WIDTH     = 3,
  parameter int POS_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  gray_step_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] DELTA_DN = '1;
  localparam logic [3:0]       ERR_MAX  = 4'd15;
  localparam logic [3:0]       ERR_LIM  = 4'(ERR_LIMIT);

  logic             s_valid;
  logic [WIDTH-1:0] s_gray;

`ifdef GRAY_DECODER_SYNC_EN
  // Gray codes change one bit per step, so a two-flop bus synchronizer never
  // yields a blend of two codes.
  logic [1:0]       vld_sync;
  logic [WIDTH-1:0] gray_s1;
  logic [WIDTH-1:0] gray_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sync <= '0;
      gray_s1  <= '0;
      gray_s2  <= '0;
    end else begin
      vld_sync <= {vld_sync[0], bus.in_valid};
      gray_s1  <= bus.gray_in;
      gray_s2  <= gray_s1;
    end
  end

  assign s_valid = vld_sync[1];
  assign s_gray  = gray_s2;
`else
  assign s_valid = bus.in_valid;
  assign s_gray  = bus.gray_in;
`endif

  logic [WIDTH-1:0] s_bin;

  // NOTE: every variable in always_comb gets a value on every path; here the
  // loop covers all bits, so no latch can be inferred.
  always_comb begin
    s_bin[WIDTH-1] = s_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      s_bin[i] = s_bin[i+1] ^ s_gray[i];
    end
  end

  state_t           state;
  logic [WIDTH-1:0] bin_q;
  logic [POS_W-1:0] pos_q;
  logic             step_up_q;
  logic             step_dn_q;
  logic             dir_q;
  logic             err_q;
  logic [3:0]       err_cnt_q;
  logic             locked_q;
  logic             fault_q;

  logic [WIDTH-1:0] delta;
  logic [3:0]       err_cnt_inc;

  assign delta       = s_bin - bin_q;
  assign err_cnt_inc = (err_cnt_q == ERR_MAX) ? ERR_MAX : err_cnt_q + 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      bin_q     <= '0;
      pos_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      err_q     <= 1'b0;

      if (bus.clr) begin
        // A sample coinciding with clr is dropped; bin_out keeps its value.
        state     <= INIT;
        pos_q     <= '0;
        err_cnt_q <= '0;
        dir_q     <= 1'b0;
        locked_q  <= 1'b0;
        fault_q   <= 1'b0;
      end else if (s_valid) begin
        unique case (state)
          INIT: begin
            bin_q    <= s_bin;
            state    <= TRACK;
            locked_q <= 1'b1;
          end

          TRACK: begin
            if (delta == DELTA_UP) begin
              step_up_q <= 1'b1;
              dir_q     <= 1'b0;
              pos_q     <= pos_q + POS_W'(1);
              bin_q     <= s_bin;
            end else if (delta == DELTA_DN) begin
              step_dn_q <= 1'b1;
              dir_q     <= 1'b1;
              pos_q     <= pos_q - POS_W'(1);
              bin_q     <= s_bin;
            end else if (delta != '0) begin
              // Illegal jump: resync to the new code but leave position alone.
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_inc;
              bin_q     <= s_bin;
              if (err_cnt_inc >= ERR_LIM) begin
                state    <= FAULT;
                locked_q <= 1'b0;
                fault_q  <= 1'b1;
              end
            end
          end

          FAULT: begin
          end

          default: begin
            state    <= INIT;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.pos_out = pos_q;
  assign bus.step_up = step_up_q;
  assign bus.step_dn = step_dn_q;
  assign bus.dir     = dir_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.locked  = locked_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Scoreboard bench for gray_step_decoder: directed scenarios plus random Gray streams,
// checked against a behavioural model. Honours GRAY_DECODER_SYNC_EN for the latency.
module tb_gray_step_decoder;

  localparam int W         = 3;
  localparam int PW        = 8;
  localparam int ERR_LIMIT = 3;
  localparam int CODES     = 1 << W;
  localparam int POS_MOD   = 1 << PW;
`ifdef GRAY_DECODER_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  typedef struct packed {
    logic [W-1:0]  bin;
    logic [PW-1:0] pos;
    logic          up;
    logic          dn;
    logic          dir;
    logic          err;
    logic [3:0]    cnt;
    logic          locked;
    logic          fault;
  } snap_t;

  typedef struct {
    int    due;
    snap_t s;
  } exp_t;

  typedef struct {
    bit v;
    int g;
  } samp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  exp_t  sb[$];
  samp_t hist[$];

  // Model state: mode 0 = waiting for first sample, 1 = tracking, 2 = faulted.
  int m_mode, m_bin, m_pos, m_dir, m_cnt;

  gray_step_decoder_if #(.WIDTH(W), .POS_W(PW)) bus ();

  gray_step_decoder #(.WIDTH(W), .POS_W(PW), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input snap_t s);
    return $sformatf("bin=%0d pos=%0d up=%0b dn=%0b dir=%0b err=%0b cnt=%0d lk=%0b ft=%0b",
                     s.bin, s.pos, s.up, s.dn, s.dir, s.err, s.cnt, s.locked, s.fault);
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.bin    = bus.bin_out;
    s.pos    = bus.pos_out;
    s.up     = bus.step_up;
    s.dn     = bus.step_dn;
    s.dir    = bus.dir;
    s.err    = bus.err;
    s.cnt    = bus.err_cnt;
    s.locked = bus.locked;
    s.fault  = bus.fault;
    return s;
  endfunction

  task automatic check(input string name, input bit ok, input string act, input string req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got [%s] expected [%s]", name, act, req);
  endtask

  // Binary of a Gray code is the XOR of all its right shifts.
  function automatic int g2b(input int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b ^= s;
    return b;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bin = 0; m_pos = 0; m_dir = 0; m_cnt = 0;
    hist.delete();
    for (int i = 0; i < SYNC_D; i++) hist.push_back('{v: 1'b0, g: 0});
  endtask

  task automatic model_step(input bit c, input bit v, input int g, output snap_t e);
    int nb, d;
    e = '0;
    if (c) begin
      m_mode = 0; m_pos = 0; m_cnt = 0; m_dir = 0;
    end else if (v && m_mode == 0) begin
      m_bin  = g2b(g);
      m_mode = 1;
    end else if (v && m_mode == 1) begin
      nb = g2b(g);
      d  = (nb - m_bin + CODES) % CODES;
      if (d == 1) begin
        e.up = 1'b1; m_dir = 0; m_pos = (m_pos + 1) % POS_MOD; m_bin = nb;
      end else if (d == CODES - 1) begin
        e.dn = 1'b1; m_dir = 1; m_pos = (m_pos + POS_MOD - 1) % POS_MOD; m_bin = nb;
      end else if (d != 0) begin
        e.err = 1'b1;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        m_bin = nb;
        if (m_cnt >= ERR_LIMIT) m_mode = 2;
      end
    end
    e.bin    = W'(m_bin);
    e.pos    = PW'(m_pos);
    e.dir    = m_dir[0];
    e.cnt    = 4'(m_cnt);
    e.locked = (m_mode == 1);
    e.fault  = (m_mode == 2);
  endtask

  // Called just after a rising edge; the core sees the synchronizer-delayed
  // sample but clr directly, and responds on the next edge.
  task automatic drive(input bit c, input bit v, input int g);
    samp_t cur, old;
    exp_t  e;
    bus.clr      = c;
    bus.in_valid = v;
    bus.gray_in  = W'(g);
    cur.v = v;
    cur.g = g;
    hist.push_back(cur);
    old = hist.pop_front();
    model_step(c, old.v, old.g, e.s);
    e.due = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input int codes[$]);
    foreach (codes[i]) drive(1'b0, 1'b1, codes[i]);
  endtask

  task automatic flush_pipe();
    repeat (SYNC_D) drive(1'b0, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        check("scoreboard_missed", 1'b0, $sformatf("cycle %0d", cyc),
              $sformatf("cycle %0d", sb[0].due));
        void'(sb.pop_front());
      end else if (sb[0].due == cyc) begin
        snap_t a;
        a = observe();
        check($sformatf("outputs@%0d", cyc), a === sb[0].s, fmt(a), fmt(sb[0].s));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int  b;
    int  r;
    bit  v;
    bit  c;
    snap_t a;

    cyc = 0; n_checks = 0; n_pass = 0;
    rst = 1'b1;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.gray_in = '0;
    model_reset();
    #12;
    a = observe();
    check("reset_values", a === snap_t'('0), fmt(a), fmt('0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Forward walk through all codes, ending back at 000.
    seq('{0, 1, 3, 2, 6, 7, 5, 4, 0});
    flush_pipe();

    // Backward across the code wrap and through position zero.
    drive(1'b1, 1'b0, 0);
    seq('{0});
    flush_pipe();
    drive(1'b1, 1'b0, 0);
    flush_pipe();
    seq('{0, 4, 5});
    flush_pipe();

    // Holds with idle gaps.
    drive(1'b1, 1'b0, 0);
    seq('{3});
    drive(1'b0, 1'b0, 3);
    seq('{3});
    drive(1'b0, 1'b0, 0);
    seq('{3});
    drive(1'b0, 1'b0, 0);
    seq('{3});
    flush_pipe();

    // Illegal jumps into FAULT, then an ignored legal sample.
    drive(1'b1, 1'b0, 0);
    seq('{0, 3, 2, 4, 6, 7});
    flush_pipe();

    // clr wins over a simultaneous sample; next sample relocks silently.
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b0, 0);
    flush_pipe();
    seq('{1, 3});
    flush_pipe();

    // Asynchronous reset between edges once position reaches 5.
    drive(1'b1, 1'b0, 0);
    flush_pipe();
    seq('{0, 1, 3, 2, 6, 7});
    flush_pipe();
    #2;
    rst = 1'b1;
    #1;
    a = observe();
    check("async_reset", a === snap_t'('0), fmt(a), fmt('0));
    sb.delete();
    model_reset();
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.gray_in = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Random Gray streams: mostly legal steps, some holds, jumps, gaps and clears.
    b = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      b = (b + 1) % CODES;
      else if (r < 70) b = (b + CODES - 1) % CODES;
      else if (r < 85) b = b;
      else             b = $urandom_range(0, CODES - 1);
      v = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 99) < 2);
      drive(c, v, b2g(b));
    end

    bus.clr = 1'b0; bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size() == 0, $sformatf("%0d pending", sb.size()), "0 pending");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
